booth_mult_n: RTL

BOOTH_MULT_N -- requirements
Module: booth_mult_n

---
 rtl/mult_pkg.sv | 24 ++
 rtl/booth_step.sv | 38 +++
 rtl/booth_mult_n.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
//   state_t    : controller states
//   iter_count : number of Booth steps for a given width and operand mode
//   cnt_width  : bit width of the iteration counter
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned operands are zero-extended by one bit, so one extra step is needed
  // to consume that extra (always 0) multiplier bit.
  function automatic int unsigned iter_count(input int unsigned width, input logic signed_mode);
    return signed_mode ? width : width + 1;
  endfunction

  // Counter must reach width+1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/subtract the multiplicand according to the
// (q0, q-1) pair, then arithmetic right shift of {acc, mplier} by one.
// Ports:
//   acc, mcand, mplier : WIDTH+1-bit accumulator, multiplicand, multiplier
//   q_prev             : Booth previous bit (q-1)
//   *_next_c           : combinational next values after the step
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] mcand,
  input  logic [WIDTH:0] mplier,
  input  logic           q_prev,
  output logic [WIDTH:0] acc_next_c,
  output logic [WIDTH:0] mplier_next_c,
  output logic           q_prev_next_c
);

  logic [WIDTH:0] sum;

  // Booth recoding of the current bit pair
  always_comb begin
    sum = acc;
    case ({mplier[0], q_prev})
      2'b10:   sum = acc - mcand;
      2'b01:   sum = acc + mcand;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift of the combined {sum, mplier} register
  always_comb begin
    acc_next_c    = {sum[WIDTH], sum[WIDTH:1]};
    mplier_next_c = {sum[0], mplier[WIDTH:1]};
    q_prev_next_c = mplier[0];
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   start               : begin a multiplication (accepted only when idle)
//   signed_mode         : 1 = two's-complement operands, 0 = unsigned
//   a_in, b_in          : multiplicand, multiplier
//   busy                : operation in progress (through the DONE cycle)
//   done                : one-cycle completion pulse
//   hi_out, lo_out      : upper/lower halves of the 2*WIDTH-bit product
module booth_mult_n
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t         state, state_nx;
  logic [WIDTH:0] mcand, acc, mplier;
  logic           q_prev;
  logic           mode_q;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  iter_c;
  logic           accept_c, step_c, finish_c;
  logic [WIDTH:0] acc_nx_c, mplier_nx_c;
  logic           q_prev_nx_c;

  assign iter_c = CW'(iter_count(WIDTH, mode_q));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc           (acc),
    .mcand         (mcand),
    .mplier        (mplier),
    .q_prev        (q_prev),
    .acc_next_c    (acc_nx_c),
    .mplier_next_c (mplier_nx_c),
    .q_prev_next_c (q_prev_nx_c)
  );

  // Next-state and control strobes
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          accept_c = 1'b1;
        end
      end
      RUN: begin
        if (cnt == iter_c) begin
          state_nx = DONE;
          finish_c = 1'b1;
        end else begin
          step_c = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_prev <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= finish_c;
      if (accept_c) begin
        mcand  <= signed_mode ? {a_in[WIDTH-1], a_in} : {1'b0, a_in};
        mplier <= signed_mode ? {b_in[WIDTH-1], b_in} : {1'b0, b_in};
        mode_q <= signed_mode;
        acc    <= '0;
        q_prev <= 1'b0;
        cnt    <= '0;
      end else if (step_c) begin
        acc    <= acc_nx_c;
        mplier <= mplier_nx_c;
        q_prev <= q_prev_nx_c;
        cnt    <= cnt + CW'(1);
      end
      // Product sits in the top bits of {acc, mplier}; signed mode made one
      // step fewer, so its product is one bit higher.
      if (finish_c) begin
        if (mode_q)
          {hi_out, lo_out} <= {acc[WIDTH-1:0], mplier[WIDTH:1]};
        else
          {hi_out, lo_out} <= {acc[WIDTH-2:0], mplier};
      end
    end
  end

endmodule
